pwm_phase_gen: RTL and testbench

Five-channel carrier-based PWM generator that consumes offset/duty pairs (top, mid 1/2, bottom 1/2) from the constant or controller source and drives the gate signals of the DC buck/boost switch leg. All five channels share one free-running carrier counter. Each channel's offset/duty is double-buffered and takes effect only at a period boundary. Outputs are registered for glitch-free gate drive.

---
 rtl/pwm_phase_gen.sv | 124 ++++++++++++
 tb/tb_pwm_phase_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_phase_gen.sv
// Five-channel carrier PWM with double-buffered offset/duty, shared counter, registered gates.
// Latency: gate reflects the previous cycle's carrier count (1 clk); no backpressure, free-running.
module pwm_phase_gen #(
  parameter int SIZE   = 13,
  parameter int PERIOD = 5000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [SIZE-1:0] offset_t,
  input  logic [SIZE-1:0] duty_t,
  input  logic [SIZE-1:0] offset_a1,
  input  logic [SIZE-1:0] duty_a1,
  input  logic [SIZE-1:0] offset_a2,
  input  logic [SIZE-1:0] duty_a2,
  input  logic [SIZE-1:0] offset_b1,
  input  logic [SIZE-1:0] duty_b1,
  input  logic [SIZE-1:0] offset_b2,
  input  logic [SIZE-1:0] duty_b2,
  output logic            gate_t,
  output logic            gate_a1,
  output logic            gate_a2,
  output logic            gate_b1,
  output logic            gate_b2,
  output logic            period_start,
  output logic            cfg_err
);

  localparam logic [SIZE-1:0] LAST  = SIZE'(PERIOD - 1);
  localparam logic [SIZE:0]   PER_W = (SIZE + 1)'(PERIOD);

  logic [SIZE-1:0] off_in [5];
  logic [SIZE-1:0] dty_in [5];

  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] off_q [5];
  logic [SIZE-1:0] off_d [5];
  logic [SIZE-1:0] dty_q [5];
  logic [SIZE-1:0] dty_d [5];
  logic [4:0]      gate_q, gate_d;
  logic            period_start_q, period_start_d;
  logic            cfg_err_q, cfg_err_d;
  logic            wrap, load;

  assign off_in[0] = offset_t;
  assign off_in[1] = offset_a1;
  assign off_in[2] = offset_a2;
  assign off_in[3] = offset_b1;
  assign off_in[4] = offset_b2;
  assign dty_in[0] = duty_t;
  assign dty_in[1] = duty_a1;
  assign dty_in[2] = duty_a2;
  assign dty_in[3] = duty_b1;
  assign dty_in[4] = duty_b2;

  // Out-of-range offsets clamp to the last count; the window may wrap past the period end.
  function automatic logic ch_on(input logic [SIZE-1:0] c,
                                 input logic [SIZE-1:0] off,
                                 input logic [SIZE-1:0] dty);
    logic [SIZE-1:0] o;
    logic [SIZE:0]   e;
    logic            r;
    o = (off > LAST) ? LAST : off;
    e = {1'b0, o} + {1'b0, dty};
    if (dty == '0)
      r = 1'b0;
    else if ({1'b0, dty} >= PER_W)
      r = 1'b1;
    else if (e <= PER_W)
      r = (c >= o) && ({1'b0, c} < e);
    else
      r = (c >= o) || ({1'b0, c} < (e - PER_W));
    return r;
  endfunction

  always_comb begin
    wrap           = en && (cnt_q == LAST);
    load           = !en || wrap;
    cnt_d          = '0;
    off_d          = off_q;
    dty_d          = dty_q;
    cfg_err_d      = cfg_err_q;
    gate_d         = '0;
    period_start_d = en && (cnt_q == '0);
    if (en && !wrap)
      cnt_d = cnt_q + SIZE'(1);
    if (load) begin
      off_d = off_in;
      dty_d = dty_in;
      for (int i = 0; i < 5; i++)
        if (off_in[i] > LAST)
          cfg_err_d = 1'b1;
    end
    for (int i = 0; i < 5; i++)
      gate_d[i] = en && ch_on(cnt_q, off_q[i], dty_q[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      off_q          <= '{default: '0};
      dty_q          <= '{default: '0};
      gate_q         <= '0;
      period_start_q <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      off_q          <= off_d;
      dty_q          <= dty_d;
      gate_q         <= gate_d;
      period_start_q <= period_start_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

  assign gate_t       = gate_q[0];
  assign gate_a1      = gate_q[1];
  assign gate_a2      = gate_q[2];
  assign gate_b1      = gate_q[3];
  assign gate_b2      = gate_q[4];
  assign period_start = period_start_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_pwm_phase_gen.sv
// Directed bench for pwm_phase_gen at PERIOD=100: per-period high counts, wrap-around,
// double buffering, clamping/cfg_err, en drop/restart and async reset.
module tb_pwm_phase_gen;
  localparam int SIZE = 13;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [SIZE-1:0] offset_t, duty_t, offset_a1, duty_a1, offset_a2, duty_a2;
  logic [SIZE-1:0] offset_b1, duty_b1, offset_b2, duty_b2;
  logic            gate_t, gate_a1, gate_a2, gate_b1, gate_b2, period_start, cfg_err;
  logic [4:0]      g;

  int total = 0;
  int bad   = 0;

  int   hi_cnt [5];
  int   first_hi [5];
  logic hist [5][100];
  int   ps_cnt;
  logic ps_at0;
  logic cfg_mid;

  pwm_phase_gen #(.SIZE(SIZE), .PERIOD(100)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .offset_t(offset_t), .duty_t(duty_t),
    .offset_a1(offset_a1), .duty_a1(duty_a1),
    .offset_a2(offset_a2), .duty_a2(duty_a2),
    .offset_b1(offset_b1), .duty_b1(duty_b1),
    .offset_b2(offset_b2), .duty_b2(duty_b2),
    .gate_t(gate_t), .gate_a1(gate_a1), .gate_a2(gate_a2),
    .gate_b1(gate_b1), .gate_b2(gate_b2),
    .period_start(period_start), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  assign g = {gate_b2, gate_b1, gate_a2, gate_a1, gate_t};

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int id);
    case (id)
      1: begin duty_t = 50; offset_b2 = 150; duty_a2 = 8191; end
      2: offset_b2 = 20;
      default: ;
    endcase
  endtask

  // One full period of samples; sample k shows the gates for carrier count k.
  task automatic measure(input int chg_k, input int chg_id);
    for (int c = 0; c < 5; c++) begin
      hi_cnt[c]   = 0;
      first_hi[c] = -1;
    end
    ps_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      for (int c = 0; c < 5; c++) begin
        hist[c][k] = g[c];
        if (g[c]) begin
          hi_cnt[c]++;
          if (first_hi[c] < 0) first_hi[c] = k;
        end
      end
      if (period_start) ps_cnt++;
      if (k == 0) ps_at0 = period_start;
      if (k == 50) cfg_mid = cfg_err;
      if (k == chg_k) apply(chg_id);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    offset_t  = 10; duty_t  = 25;
    offset_a1 = 5;  duty_a1 = 0;
    offset_a2 = 0;  duty_a2 = 100;
    offset_b1 = 90; duty_b1 = 20;
    offset_b2 = 20; duty_b2 = 30;
    step(); step();
    chk("rst_gates", int'(g), 0);
    chk("rst_ps", int'(period_start), 0);
    chk("rst_cfg", int'(cfg_err), 0);

    rst_n = 1'b1;
    step(); step(); step();
    chk("idle_gates", int'(g), 0);
    chk("idle_ps", int'(period_start), 0);

    // period 1
    en = 1'b1;
    measure(-1, 0);
    chk("p1_ps_at0", int'(ps_at0), 1);
    chk("p1_ps_cnt", ps_cnt, 1);
    chk("p1_t_cnt", hi_cnt[0], 25);
    chk("p1_t_first", first_hi[0], 10);
    chk("p1_a1_cnt", hi_cnt[1], 0);
    chk("p1_a2_cnt", hi_cnt[2], 100);
    chk("p1_b1_cnt", hi_cnt[3], 20);
    chk("p1_b1_first", first_hi[3], 0);
    chk("p1_b1_9", int'(hist[3][9]), 1);
    chk("p1_b1_10", int'(hist[3][10]), 0);
    chk("p1_b1_89", int'(hist[3][89]), 0);
    chk("p1_b1_90", int'(hist[3][90]), 1);
    chk("p1_b2_cnt", hi_cnt[4], 30);
    chk("p1_b2_first", first_hi[4], 20);

    // period 2: inputs change with carrier at 40
    measure(39, 1);
    chk("p2_ps_cnt", ps_cnt, 1);
    chk("p2_t_cnt", hi_cnt[0], 25);
    chk("p2_b2_first", first_hi[4], 20);
    chk("p2_cfg_mid", int'(cfg_mid), 0);

    // period 3: new values take effect, offset_b2 clamps to 99
    measure(-1, 0);
    chk("p3_t_cnt", hi_cnt[0], 50);
    chk("p3_t_first", first_hi[0], 10);
    chk("p3_a2_cnt", hi_cnt[2], 100);
    chk("p3_b2_cnt", hi_cnt[4], 30);
    chk("p3_b2_28", int'(hist[4][28]), 1);
    chk("p3_b2_29", int'(hist[4][29]), 0);
    chk("p3_b2_98", int'(hist[4][98]), 0);
    chk("p3_b2_99", int'(hist[4][99]), 1);
    chk("p3_cfg", int'(cfg_mid), 1);

    // period 4: offset_b2 corrected mid-period, still clamped here
    measure(10, 2);
    chk("p4_b2_first", first_hi[4], 0);
    chk("p4_cfg", int'(cfg_mid), 1);

    measure(-1, 0);
    chk("p5_b2_first", first_hi[4], 20);
    chk("p5_b2_cnt", hi_cnt[4], 30);
    chk("p5_cfg_sticky", int'(cfg_err), 1);

    // en dropped at carrier 30 for 7 clocks
    for (int i = 0; i < 30; i++) step();
    chk("pre_drop_a2", int'(gate_a2), 1);
    en = 1'b0;
    offset_t = 0; duty_t = 5;
    step();
    chk("drop_gates", int'(g), 0);
    chk("drop_ps", int'(period_start), 0);
    for (int i = 0; i < 6; i++) step();
    chk("idle2_gates", int'(g), 0);
    en = 1'b1;
    step();
    chk("restart_ps", int'(period_start), 1);
    chk("restart_gates", int'(g), 5'b01101);
    step();
    chk("restart_ps_off", int'(period_start), 0);

    // async reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gates", int'(g), 0);
    chk("arst_ps", int'(period_start), 0);
    chk("arst_cfg", int'(cfg_err), 0);
    step();
    rst_n = 1'b1;
    measure(-1, 0);
    chk("post_rst_ps_at0", int'(ps_at0), 1);
    chk("post_rst_t_cnt", hi_cnt[0], 0);
    chk("post_rst_a2_cnt", hi_cnt[2], 0);
    chk("post_rst_b1_cnt", hi_cnt[3], 0);
    measure(-1, 0);
    chk("reload_t_cnt", hi_cnt[0], 5);
    chk("reload_t_first", first_hi[0], 0);
    chk("reload_a2_cnt", hi_cnt[2], 100);
    chk("reload_b1_cnt", hi_cnt[3], 20);
    chk("reload_cfg", int'(cfg_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
